// File: rtl/clock_measure_ctrl.sv
// Measurement sequencer for the clock period/duty tester: lock wait, tester reset and settle,
// then accumulates 2**NS_LOG2 period samples and reports avg/min/max period, avg high time, pass.
module clock_measure_ctrl #(
  parameter int W          = 16,
  parameter int NS_LOG2    = 4,
  parameter int SAMPLE_GAP = 1024,
  parameter int SETTLE     = 4096,
  parameter int LOCK_TO    = 65536
) (
  input  logic           clk_fst,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic           locked,
  input  logic [W-1:0]   ht_in,
  input  logic [W-1:0]   lt_in,
  input  logic [W:0]     exp_min,
  input  logic [W:0]     exp_max,
  output logic           tester_rst_n,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           timeout,
  output logic [W:0]     period_avg,
  output logic [W:0]     period_min,
  output logic [W:0]     period_max,
  output logic [W-1:0]   ht_avg
);

  localparam int NS = 1 << NS_LOG2;
  localparam int PW = W + 1;
  localparam int SW = PW + NS_LOG2;
  localparam int HW = W + NS_LOG2;
  localparam int GW = $clog2(SAMPLE_GAP);
  localparam int TW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOCK_TO + 1);
  localparam int CW = NS_LOG2 + 1;

  localparam logic [GW-1:0] GAP_LAST    = GW'(SAMPLE_GAP - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TO - 1);
  localparam logic [CW-1:0] NS_LAST     = CW'(NS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOCKWAIT, S_SETTLE, S_SAMPLE, S_CHECK, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [TW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]  ns_cnt_q, ns_cnt_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [HW-1:0]  hsum_q, hsum_d;
  logic [PW-1:0]  pmin_q, pmin_d, pmax_q, pmax_d;
  logic           tester_rst_n_q, tester_rst_n_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           pass_q, pass_d, timeout_q, timeout_d;
  logic [PW-1:0]  period_avg_q, period_avg_d;
  logic [PW-1:0]  period_min_q, period_min_d;
  logic [PW-1:0]  period_max_q, period_max_d;
  logic [W-1:0]   ht_avg_q, ht_avg_d;

  logic [PW-1:0]  p_c, avg_c;
  logic [W-1:0]   hav_c;
  logic           clr_acc, clr_res;

  // Period is formed one bit wider so 2*(2**W-1) never wraps.
  assign p_c   = PW'(ht_in) + PW'(lt_in);
  assign avg_c = PW'(sum_q >> NS_LOG2);
  assign hav_c = W'(hsum_q >> NS_LOG2);

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    settle_cnt_d = settle_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ns_cnt_d     = ns_cnt_q;
    sum_d        = sum_q;
    hsum_d       = hsum_q;
    pmin_d       = pmin_q;
    pmax_d       = pmax_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    period_avg_d = period_avg_q;
    period_min_d = period_min_q;
    period_max_d = period_max_q;
    ht_avg_d     = ht_avg_q;
    clr_acc      = 1'b0;
    clr_res      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_acc = 1'b1;
          clr_res = 1'b1;
          state_d = S_LOCKWAIT;
        end
      end
      S_LOCKWAIT: begin
        if (locked) begin
          settle_cnt_d = '0;
          state_d      = S_SETTLE;
        end else if (lock_cnt_q == LOCK_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!locked) begin
          clr_acc = 1'b1;
          state_d = S_LOCKWAIT;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (!locked) begin
          clr_acc = 1'b1;
          state_d = S_LOCKWAIT;
        end else if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          sum_d     = sum_q + SW'(p_c);
          hsum_d    = hsum_q + HW'(ht_in);
          if (ns_cnt_q == '0 || p_c < pmin_q) pmin_d = p_c;
          if (ns_cnt_q == '0 || p_c > pmax_q) pmax_d = p_c;
          if (ns_cnt_q == NS_LAST) state_d = S_CHECK;
          else                     ns_cnt_d = ns_cnt_q + 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        period_avg_d = avg_c;
        ht_avg_d     = hav_c;
        period_min_d = pmin_q;
        period_max_d = pmax_q;
        // An inverted window (exp_min > exp_max) can never satisfy both bounds.
        pass_d       = (exp_min <= avg_c) && (avg_c <= exp_max);
        state_d      = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      clr_acc = 1'b1;
      clr_res = 1'b1;
      state_d = S_IDLE;
    end

    if (clr_acc) begin
      lock_cnt_d   = '0;
      settle_cnt_d = '0;
      gap_cnt_d    = '0;
      ns_cnt_d     = '0;
      sum_d        = '0;
      hsum_d       = '0;
      pmin_d       = '0;
      pmax_d       = '0;
    end
    if (clr_res) begin
      pass_d       = 1'b0;
      timeout_d    = 1'b0;
      period_avg_d = '0;
      period_min_d = '0;
      period_max_d = '0;
      ht_avg_d     = '0;
    end

    tester_rst_n_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d         = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk_fst) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      lock_cnt_q     <= '0;
      settle_cnt_q   <= '0;
      gap_cnt_q      <= '0;
      ns_cnt_q       <= '0;
      sum_q          <= '0;
      hsum_q         <= '0;
      pmin_q         <= '0;
      pmax_q         <= '0;
      tester_rst_n_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      timeout_q      <= 1'b0;
      period_avg_q   <= '0;
      period_min_q   <= '0;
      period_max_q   <= '0;
      ht_avg_q       <= '0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      ns_cnt_q       <= ns_cnt_d;
      sum_q          <= sum_d;
      hsum_q         <= hsum_d;
      pmin_q         <= pmin_d;
      pmax_q         <= pmax_d;
      tester_rst_n_q <= tester_rst_n_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      timeout_q      <= timeout_d;
      period_avg_q   <= period_avg_d;
      period_min_q   <= period_min_d;
      period_max_q   <= period_max_d;
      ht_avg_q       <= ht_avg_d;
    end
  end

  assign tester_rst_n = tester_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign period_avg   = period_avg_q;
  assign period_min   = period_min_q;
  assign period_max   = period_max_q;
  assign ht_avg       = ht_avg_q;

endmodule
